// File: rtl/twos_to_signmag_serial.sv
// rtl/twos_to_signmag_serial.sv - bit-serial two's-complement to sign-magnitude converter (optional saturation: TWOS_SIGNMAG_SAT_EN)
module twos_to_signmag_serial #(
    parameter int DATA_WID = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_WID-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [DATA_WID-2:0] out_mag,
    output logic                out_ovf,
    output logic                busy
);

    localparam int MW = DATA_WID - 1;
    localparam int CW = $clog2(DATA_WID);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [MW-1:0]   data_r;
    logic [MW-1:0]   mag_r;
    logic            sign_r;
    logic            seen_one;
    logic [CW-1:0]   cnt;
    logic            cur_bit;
    logic            out_bit;
    logic            last_bit;

    // Bits are consumed LSB first from the shift register; once a 1 has gone by
    // on a negative word, every later bit is inverted (serial negation).
    assign cur_bit  = data_r[0];
    assign out_bit  = cur_bit ^ (sign_r & seen_one);
    assign last_bit = (cnt == CW'(MW - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CONV;
            CONV:    if (last_bit) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch at acceptance, shift one bit per CONV clock
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= '0;
            mag_r    <= '0;
            sign_r   <= 1'b0;
            seen_one <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r   <= in_data[MW-1:0];
                        sign_r   <= in_data[DATA_WID-1];
                        seen_one <= 1'b0;
                        cnt      <= '0;
                    end
                end
                CONV: begin
                    data_r   <= data_r >> 1;
                    mag_r    <= {out_bit, mag_r[MW-1:1]};
                    seen_one <= seen_one | cur_bit;
                    cnt      <= cnt + 1'b1;
`ifdef TWOS_SIGNMAG_SAT_EN
                    // Negative with no 1 in the low bits is the most negative value
                    if (last_bit && sign_r && !seen_one && !cur_bit) begin
                        mag_r <= '1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef TWOS_SIGNMAG_SAT_EN
    logic ovf_r;

    // Overflow flag: cleared at acceptance, set on the final bit of the most negative word
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            ovf_r <= 1'b0;
        end else if (state == CONV && last_bit) begin
            ovf_r <= sign_r & ~seen_one & ~cur_bit;
        end
    end

    assign out_ovf = ovf_r;
`else
    // Without saturation the most negative word wraps to magnitude 0
    assign out_ovf = 1'b0;
`endif

    assign out_sign = sign_r;
    assign out_mag  = mag_r;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// tb/tb_twos_to_signmag_serial.sv - scoreboard bench for twos_to_signmag_serial
module tb_twos_to_signmag_serial;

    localparam int DW = 17;
    localparam int MW = DW - 1;

    typedef struct packed {
        logic          sign;
        logic [MW-1:0] mag;
        logic          ovf;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [MW-1:0] out_mag;
    logic          out_ovf;
    logic          busy;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    res_t exp_q[$];

    twos_to_signmag_serial #(.DATA_WID(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: every completed output handshake is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("out_sign", {31'd0, out_sign}, {31'd0, e.sign});
                chk("out_mag",  {16'd0, out_mag},  {16'd0, e.mag});
                chk("out_ovf",  {31'd0, out_ovf},  {31'd0, e.ovf});
            end
        end
    end

    // Issue one word, verify latency, optionally hold the result, then release it.
    // With noisy=1, in_valid stays high with changing data throughout CONV and DONE.
    task automatic run_word(input logic [DW-1:0] d, input res_t e, input int hold, input bit noisy);
        int lat;
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!noisy) in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (noisy) in_data = DW'($urandom);
            if (out_valid) break;
        end
        chk("latency", lat, 32'd16);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (noisy) in_data = DW'($urandom);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sign",  {31'd0, out_sign},  {31'd0, e.sign});
            chk("hold_mag",   {16'd0, out_mag},   {16'd0, e.mag});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_after_release", {31'd0, out_valid}, 32'd0);
        chk("busy_after_release", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
    endtask

    function automatic res_t mk(input logic s, input logic [MW-1:0] m, input logic o);
        res_t r;
        r.sign = s;
        r.mag  = m;
        r.ovf  = o;
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_mag",   {16'd0, out_mag},   32'd0);
        chk("rst_out_sign",  {31'd0, out_sign},  32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);

        run_word(17'h00005, mk(1'b0, 16'h0005, 1'b0), 0, 1'b0);
        run_word(17'h1FFFB, mk(1'b1, 16'h0005, 1'b0), 0, 1'b0);
`ifdef TWOS_SIGNMAG_SAT_EN
        run_word(17'h10000, mk(1'b1, 16'hFFFF, 1'b1), 0, 1'b0);
`else
        run_word(17'h10000, mk(1'b1, 16'h0000, 1'b0), 0, 1'b0);
`endif
        run_word(17'h18000, mk(1'b1, 16'h8000, 1'b0), 10, 1'b0);
        run_word(17'h1FFFF, mk(1'b1, 16'h0001, 1'b0), 0, 1'b0);
        run_word(17'h0FFFF, mk(1'b0, 16'hFFFF, 1'b0), 0, 1'b0);
        run_word(17'h00000, mk(1'b0, 16'h0000, 1'b0), 0, 1'b0);
        run_word(17'h1FFFB, mk(1'b1, 16'h0005, 1'b0), 3, 1'b1);

        // Reset on the 8th CONV clock discards the word in flight
        @(negedge clk);
        in_data  = 17'h1ABCD;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy",      {31'd0, busy},      32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out_mag",   {16'd0, out_mag},   32'd0);
        run_word(17'h00003, mk(1'b0, 16'h0003, 1'b0), 0, 1'b0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
